// File: rtl/instruction_memory_banked_pkg.sv
// Shared defaults and types for the banked layer-instruction store.
package instruction_memory_banked_pkg;

  localparam int unsigned IM_WIDTH  = 16;
  localparam int unsigned IM_FIELDS = 24;
  localparam int unsigned IM_DEPTH  = 32;
  localparam int unsigned NUM_BANKS = 2;
  localparam int unsigned EXT_W     = 32;

  typedef logic [IM_WIDTH-1:0] im_word_t;

  typedef enum logic [0:0] {
    IM_IDLE,
    IM_SWAP_WAIT
  } im_state_e;

endpackage

// File: rtl/instruction_memory_banked_im_bank.sv
// One instruction bank: Depth x Fields registers, sync clear, one write port and a
// combinational whole-layer read.
module instruction_memory_banked_im_bank #(
  parameter int unsigned Width  = 16,
  parameter int unsigned Fields = 24,
  parameter int unsigned Depth  = 32,
  localparam int unsigned FieldAw = $clog2(Fields),
  localparam int unsigned LayerAw = $clog2(Depth)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [LayerAw-1:0] wr_layer_i,
  input  logic [FieldAw-1:0] wr_field_i,
  input  logic [Width-1:0]   wr_data_i,
  input  logic [LayerAw-1:0] rd_layer_i,
  output logic [Width-1:0]   rd_data_o [Fields]
);

  logic [Width-1:0] mem_q [Depth][Fields];
  logic [Width-1:0] mem_d [Depth][Fields];

  // Caller guarantees wr_layer_i/wr_field_i are in range whenever we_i is high.
  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[wr_layer_i][wr_field_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_o = mem_q[rd_layer_i];

endmodule

// File: rtl/instruction_memory_banked.sv
// Round-robin banked layer-instruction store: host writes the shadow bank, engine fetches
// the active bank, and a swap handshake promotes the shadow once the engine is idle.
module instruction_memory_banked
  import instruction_memory_banked_pkg::im_state_e;
  import instruction_memory_banked_pkg::IM_IDLE;
  import instruction_memory_banked_pkg::IM_SWAP_WAIT;
#(
  parameter int unsigned IM_WIDTH  = instruction_memory_banked_pkg::IM_WIDTH,
  parameter int unsigned IM_FIELDS = instruction_memory_banked_pkg::IM_FIELDS,
  parameter int unsigned IM_DEPTH  = instruction_memory_banked_pkg::IM_DEPTH,
  parameter int unsigned NUM_BANKS = instruction_memory_banked_pkg::NUM_BANKS,
  parameter int unsigned EXT_W     = instruction_memory_banked_pkg::EXT_W,
  localparam int unsigned BW = $clog2(NUM_BANKS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_ext_im,
  input  logic [EXT_W-1:0]    wr_addr_ext_im,
  input  logic [EXT_W-1:0]    wr_data_ext_im,
  output logic                wr_err,
  input  logic                fetch_req,
  input  logic [31:0]         pc,
  output logic [IM_WIDTH-1:0] instruction [IM_FIELDS],
  output logic                fetch_valid,
  output logic                fetch_err,
  input  logic                engine_busy,
  input  logic                swap_req,
  output logic                swap_pending,
  output logic                swap_done,
  output logic [BW-1:0]       active_bank
);

  localparam int unsigned FA = $clog2(IM_FIELDS);
  localparam int unsigned LA = $clog2(IM_DEPTH);

  function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
    return (32'(b) == NUM_BANKS - 1) ? '0 : b + 1'b1;
  endfunction

  // Write decode and range check
  logic [FA-1:0] wr_field;
  logic [LA-1:0] wr_layer;
  logic          wr_ok;
  logic [BW-1:0] shadow_bank;
  logic          unused_bits;

  assign wr_field    = wr_addr_ext_im[FA-1:0];
  assign wr_layer    = wr_addr_ext_im[FA+LA-1:FA];
  assign wr_ok       = (32'(wr_field) < IM_FIELDS) && (32'(wr_layer) < IM_DEPTH);
  assign unused_bits = ^{wr_addr_ext_im[EXT_W-1:FA+LA], wr_data_ext_im[EXT_W-1:IM_WIDTH]};

  // Banks
  logic [NUM_BANKS-1:0] bank_we;
  logic [IM_WIDTH-1:0]  bank_rdata [NUM_BANKS][IM_FIELDS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_we[b] = wr_en_ext_im & wr_ok & (shadow_bank == BW'(b));

    instruction_memory_banked_im_bank #(
      .Width  (IM_WIDTH),
      .Fields (IM_FIELDS),
      .Depth  (IM_DEPTH)
    ) u_bank (
      .clk_i      (clk),
      .rst_i      (reset),
      .we_i       (bank_we[b]),
      .wr_layer_i (wr_layer),
      .wr_field_i (wr_field),
      .wr_data_i  (wr_data_ext_im[IM_WIDTH-1:0]),
      .rd_layer_i (pc[LA-1:0]),
      .rd_data_o  (bank_rdata[b])
    );
  end

  // State
  im_state_e           state_q, state_d;
  logic [BW-1:0]       active_bank_q, active_bank_d;
  logic                commit;
  logic                swap_done_q, swap_done_d;
  logic                wr_err_q, wr_err_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic                fetch_err_q, fetch_err_d;
  logic                pc_ok;
  logic [IM_WIDTH-1:0] instruction_q [IM_FIELDS];
  logic [IM_WIDTH-1:0] instruction_d [IM_FIELDS];

  assign shadow_bank = bank_inc(active_bank_q);
  assign pc_ok       = pc < IM_DEPTH;

  // Swap FSM; every decision uses the pre-commit active bank.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      IM_IDLE: begin
        if (swap_req) begin
          if (engine_busy) begin
            state_d = IM_SWAP_WAIT;
          end else begin
            commit = 1'b1;
          end
        end
      end
      IM_SWAP_WAIT: begin
        if (!engine_busy) begin
          commit  = 1'b1;
          state_d = IM_IDLE;
        end
      end
    endcase
    active_bank_d = commit ? shadow_bank : active_bank_q;
    swap_done_d   = commit;
  end

  // Fetch path and error flags
  always_comb begin
    instruction_d = instruction_q;
    fetch_valid_d = fetch_req;
    fetch_err_d   = fetch_req & ~pc_ok;
    wr_err_d      = wr_en_ext_im & ~wr_ok;
    if (fetch_req) begin
      for (int f = 0; f < int'(IM_FIELDS); f++) begin
        instruction_d[f] = pc_ok ? bank_rdata[active_bank_q][f] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IM_IDLE;
      active_bank_q <= '0;
      swap_done_q   <= 1'b0;
      wr_err_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      instruction_q <= '{default: '0};
    end else begin
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
      swap_done_q   <= swap_done_d;
      wr_err_q      <= wr_err_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      instruction_q <= instruction_d;
    end
  end

  assign wr_err       = wr_err_q;
  assign fetch_valid  = fetch_valid_q;
  assign fetch_err    = fetch_err_q;
  assign swap_done    = swap_done_q;
  assign swap_pending = (state_q == IM_SWAP_WAIT);
  assign active_bank  = active_bank_q;
  assign instruction  = instruction_q;

endmodule
